// File: rtl/seg_scan_pkg.sv
// Shared definitions for the scanned seven-segment capture block:
// FSM states, the 16 hex glyph patterns (a=bit6 .. g=bit0, active-high)
// and the digit count.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  typedef enum logic [1:0] {
    WAIT_STABLE,
    HOLD,
    LOST
  } scan_state_t;

  // Glyphs for 0-9, A, b, C, d, E, F; the index is the decoded value.
  localparam logic [6:0] SEG_PAT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Position of the set bit of a one-hot digit select.
  function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
    onehot_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) onehot_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to hex decoder. Unknown patterns decode to
// value 0 with valid low.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       valid
);

  // Compare the pattern against every hex glyph.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    value = 4'h0;
    valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PAT[i]) begin
        value = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures the digits of a multiplexed seven-segment display into a frame.
// Each digit is sampled once per dwell after ComOut/segOut have been stable
// for SETTLE_CYC cycles; a frame is published once all 8 digits are seen.
// Optional feature: define SEG_SCAN_TIMEOUT_EN to enable the scan-lost
// timeout (TIMEOUT_CYC, LOST state, scan_lost); otherwise scan_lost is 0.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYC     = 2,
  parameter int TIMEOUT_CYC    = 256,
  parameter bit COM_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  ComOut,
  input  logic [6:0]  segOut,
  output logic [31:0] digit_o,
  output logic [7:0]  digit_vld,
  output logic        frame_done,
  output logic        err_com,
  output logic        scan_lost
);

  localparam int STAB_W = $clog2(SETTLE_CYC + 1);
  localparam logic [STAB_W-1:0] SETTLE_MAX = STAB_W'(SETTLE_CYC);
  localparam logic [STAB_W-1:0] SETTLE_M1  = STAB_W'(SETTLE_CYC - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  logic [7:0]            com_q, com_p;
  logic [6:0]            seg_q, seg_p;
  scan_state_t           state;
  logic [STAB_W-1:0]     stab_cnt;
  logic [NUM_DIGITS-1:0] seen, work_vld, vld_nx, sel;
  logic [31:0]           work_val, val_nx;
  logic [2:0]            slot;
  logic [3:0]            dec_val;
  logic                  dec_vld;
  logic                  same, is_onehot, settled, do_cap, do_err, to_hit, frame_end;

  // Input register plus one cycle of history for the stability compare.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      com_q <= '0;
      seg_q <= '0;
      com_p <= '0;
      seg_p <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      com_q <= ComOut;
      seg_q <= segOut;
      com_p <= com_q;
      seg_p <= seg_q;
    end
  end

  assign same      = (com_q == com_p) && (seg_q == seg_p);
  assign sel       = COM_ACTIVE_LOW ? ~com_q : com_q;
  assign is_onehot = $onehot(sel);
  assign slot      = onehot_idx(sel);
  // HOLD never samples, so a dwell yields at most one capture.
  assign settled   = same && (stab_cnt == SETTLE_M1) && (state != HOLD);
  assign do_cap    = settled && is_onehot;
  assign do_err    = settled && !is_onehot;
  assign frame_end = do_cap && ((seen | sel) == ALL_SEEN);

  seg7_decode u_dec (
    .seg   (seg_q),
    .value (dec_val),
    .valid (dec_vld)
  );

  // Working bank with the current capture merged in.
  always_comb begin
    val_nx = work_val;
    vld_nx = work_vld;
    val_nx[{slot, 2'b00} +: 4] = dec_val;
    vld_nx[slot] = dec_vld;
  end

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_M1  = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (state != LOST) && !do_cap && (to_cnt == TO_M1);

  // Saturating timeout since the last capture; scan_lost mirrors LOST.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      to_cnt    <= '0;
      scan_lost <= 1'b0;
    end else if (do_cap) begin
      to_cnt    <= '0;
      scan_lost <= 1'b0;
    end else begin
      if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
      if (to_hit) scan_lost <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign scan_lost = 1'b0;
  // TIMEOUT_CYC has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  // Scan FSM: stability counting, dwell hold and loss detection.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= WAIT_STABLE;
      stab_cnt <= '0;
      err_com  <= 1'b0;
    end else begin
      err_com <= do_err;
      // Saturating so LOST samples once per dwell without a separate hold.
      if (!same || (state == WAIT_STABLE && settled)) stab_cnt <= '0;
      else if (stab_cnt != SETTLE_MAX)                stab_cnt <= stab_cnt + STAB_W'(1);
      case (state)
        WAIT_STABLE: if (to_hit) state <= LOST; else if (settled) state <= HOLD;
        HOLD:        if (to_hit) state <= LOST; else if (!same) state <= WAIT_STABLE;
        // LOST: the first good capture is recorded and normal scanning resumes.
        default:     if (do_cap) state <= HOLD;
      endcase
    end
  end

  // Working bank, seen mask and atomic frame publication.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      // NOTE: the bank is reset as well so a partial frame never leaks past reset.
      seen       <= '0;
      work_val   <= '0;
      work_vld   <= '0;
      digit_o    <= '0;
      digit_vld  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (do_cap) begin
        work_val <= val_nx;
        work_vld <= vld_nx;
        seen     <= frame_end ? '0 : (seen | sel);
      end else if (to_hit) begin
        seen <= '0;
      end
      if (frame_end) begin
        digit_o   <= val_nx;
        digit_vld <= vld_nx;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture (SETTLE_CYC=2,
// TIMEOUT_CYC=256, active-low ComOut). Timeout expectations follow
// SEG_SCAN_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_seg_scan_capture;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  ComOut = 8'hFF;
  logic [6:0]  segOut = 7'h00;
  logic [31:0] digit_o;
  logic [7:0]  digit_vld;
  logic        frame_done, err_com, scan_lost;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int err_cnt = 0;

`ifdef SEG_SCAN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Hex glyphs a..g = bit6..bit0.
  logic [6:0] glyph [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  seg_scan_capture #(
    .SETTLE_CYC     (2),
    .TIMEOUT_CYC    (256),
    .COM_ACTIVE_LOW (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ComOut     (ComOut),
    .segOut     (segOut),
    .digit_o    (digit_o),
    .digit_vld  (digit_vld),
    .frame_done (frame_done),
    .err_com    (err_com),
    .scan_lost  (scan_lost)
  );

  always #5 CLK = ~CLK;

  // Pulse counters, sampled on the falling edge.
  always @(negedge CLK) begin
    if (frame_done) fd_cnt++;
    if (err_com)    err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Select digit d (active-low) showing pat for n cycles.
  task automatic show(input int d, input logic [6:0] pat, input int n);
    logic [7:0] one;
    one    = 8'h01;
    ComOut = ~(one << d);
    segOut = pat;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    ComOut = 8'hFF;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int fd0, err0;
    logic [7:0] one;
    one = 8'h01;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_digit_o",    digit_o,    32'h0);
    check("rst_digit_vld",  digit_vld,  32'h0);
    check("rst_frame_done", frame_done, 32'h0);
    check("rst_err_com",    err_com,    32'h0);
    check("rst_scan_lost",  scan_lost,  32'h0);
    RST = 1'b1;
    idle(8);

    // Full scan 1..8, dwell 8
    fd0 = fd_cnt; err0 = err_cnt;
    for (int d = 0; d < 7; d++) show(d, glyph[d+1], 8);
    check("no_frame_before_8th", fd_cnt - fd0, 0);
    show(7, glyph[8], 8);
    check("scan1_frames",    fd_cnt - fd0,  1);
    check("scan1_digit_o",   digit_o,       32'h87654321);
    check("scan1_digit_vld", digit_vld,     32'hFF);
    check("scan1_no_err",    err_cnt - err0, 0);

    // Digit 3 overwritten with an illegal pattern
    fd0 = fd_cnt;
    show(0, glyph[10], 8);
    show(1, glyph[11], 8);
    show(2, glyph[12], 8);
    show(3, glyph[8],  8);
    show(3, 7'h01,     8);
    check("repeat_no_frame", fd_cnt - fd0, 0);
    show(4, glyph[14], 8);
    show(5, glyph[15], 8);
    show(6, glyph[0],  8);
    show(7, glyph[9],  8);
    check("scan2_frames",    fd_cnt - fd0, 1);
    check("scan2_digit_o",   digit_o,      32'h90FE0CBA);
    check("scan2_digit_vld", digit_vld,    32'hF7);

    // Non-one-hot stable ComOut
    idle(8);
    err0 = err_cnt; fd0 = fd_cnt;
    ComOut = 8'hF3;
    repeat (8) @(posedge CLK);
    #1;
    ComOut = 8'hFF;
    repeat (2) @(posedge CLK);
    #1;
    check("bad_com_err_once", err_cnt - err0, 1);
    check("bad_com_no_frame", fd_cnt - fd0,   0);
    idle(6);

    // Reset mid-frame discards the working bank
    for (int d = 0; d < 5; d++) show(d, glyph[5], 8);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("midrst_digit_o",   digit_o,   32'h0);
    check("midrst_digit_vld", digit_vld, 32'h0);
    RST = 1'b1;
    fd0 = fd_cnt;
    show(5, glyph[5], 8);
    show(6, glyph[6], 8);
    show(7, glyph[7], 8);
    check("postrst_partial_no_frame", fd_cnt - fd0, 0);
    for (int d = 0; d < 5; d++) show(d, glyph[d], 8);
    check("postrst_frames",    fd_cnt - fd0, 1);
    check("postrst_digit_o",   digit_o,      32'h76543210);
    check("postrst_digit_vld", digit_vld,    32'hFF);

    // Too-short dwell: no capture at all
    check("fast_lost_before", scan_lost, 32'h0);
    fd0 = fd_cnt; err0 = err_cnt;
    for (int i = 0; i < 300; i++) begin
      ComOut = ~(one << (i % 8));
      segOut = glyph[3];
      @(posedge CLK);
      #1;
    end
    check("fast_no_frame", fd_cnt - fd0,   0);
    check("fast_no_err",   err_cnt - err0, 0);
    check("fast_lost",     scan_lost,      TO_EN);

    // Capture clears loss; halt 256 cycles sets it again
    show(0, glyph[1], 5);
    check("recover_lost_low", scan_lost, 32'h0);
    show(0, glyph[1], 3);
    idle(250);
    check("halt_before_timeout", scan_lost, 32'h0);
    idle(4);
    check("halt_after_timeout", scan_lost, TO_EN);

    // Resume scanning after the halt
    fd0 = fd_cnt;
    show(0, glyph[8], 8);
    check("resume_lost_low", scan_lost, 32'h0);
    for (int d = 1; d < 8; d++) show(d, glyph[d+8], 8);
    check("resume_frames",    fd_cnt - fd0, 1);
    check("resume_digit_o",   digit_o,      32'hFEDCBA98);
    check("resume_digit_vld", digit_vld,    32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: consecutive identical cycles of ComOut/segOut required before a digit is sampled.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256: cycles without a valid capture before the scan is declared lost.
REQ-003 SHALL have parameter COM_ACTIVE_LOW, default 1: when 1, the selected digit is the ComOut bit driven 0.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port ComOut, input, 8 bits: digit-select lines of the scanned display; bit i selects digit i.
REQ-007 SHALL have port segOut, input, 7 bits: segment lines, active-high, bit6=a through bit0=g.
REQ-008 SHALL have port digit_o, output, 32 bits: last complete frame; nibble i holds the hex value of digit i.
REQ-009 SHALL have port digit_vld, output, 8 bits: bit i is 1 when nibble i of the last frame decoded to a legal pattern.
REQ-010 SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit_o/digit_vld update.
REQ-011 SHALL have port err_com, output, 1 bit: one-cycle pulse when a stable ComOut is not one-hot (per COM_ACTIVE_LOW).
REQ-012 SHALL have port scan_lost, output, 1 bit: level, high while no valid capture has occurred for TIMEOUT_CYC cycles.

Function
REQ-013 SHALL register ComOut/segOut once at the input; all decisions use registered values; added latency 1 cycle.
REQ-014 SHALL implement FSM states WAIT_STABLE, HOLD, LOST.
REQ-015 WAIT_STABLE: a stability counter SHALL increment while registered {ComOut,segOut} equals its previous value, and SHALL clear on any change.
REQ-016 When the counter reaches SETTLE_CYC with one-hot ComOut, the block SHALL decode segOut, write the nibble and valid bit into working-bank slot i, set seen[i], and go to HOLD.
REQ-017 When the counter reaches SETTLE_CYC with a non-one-hot ComOut (including all-inactive), the block SHALL pulse err_com, write nothing, and go to HOLD.
REQ-018 HOLD: the block SHALL stay until registered ComOut or segOut changes, then return to WAIT_STABLE with the counter cleared, so one dwell yields at most one capture.
REQ-019 Decode SHALL map the 16 standard hex patterns (0-9, A, b, C, d, E, F) to 0x0-0xF; any other pattern SHALL write nibble 0x0 with valid bit 0.
REQ-020 In the cycle that seen becomes 8'hFF, the block SHALL copy the working bank to digit_o/digit_vld, pulse frame_done the following cycle, and clear seen, all atomically.
REQ-021 A repeated capture of a digit already in seen SHALL overwrite its working slot without ending the frame.
REQ-022 A timeout counter SHALL clear on every valid capture and saturate at TIMEOUT_CYC; on reaching it, FSM SHALL enter LOST, assert scan_lost, and clear seen.
REQ-023 LOST: scan_lost SHALL deassert and the FSM SHALL resume WAIT_STABLE on the first valid capture (REQ-016), which SHALL be recorded.
REQ-024 A capture and frame completion in the same cycle SHALL include that capture in the published frame.

Reset
REQ-025 While RST=0 at a clock edge: digit_o=0, digit_vld=0, frame_done=0, err_com=0, scan_lost=0, seen=0, all counters 0, and FSM=WAIT_STABLE.
REQ-026 Reset mid-frame SHALL discard the working bank; the first frame_done after reset SHALL require all 8 digits to be captured anew.

Configuration
REQ-027 With macro SEG_SCAN_TIMEOUT_EN defined, REQ-022/023 SHALL apply; without it, the timeout counter and LOST state SHALL be absent, scan_lost SHALL be tied 0, and TIMEOUT_CYC SHALL be ignored.

Structure
REQ-028 Package seg_scan_pkg SHALL hold the FSM state enum, the 16-entry segment pattern constants, and the digit-count constant 8.
REQ-029 A sub-module seg7_decode (combinational: 7-bit pattern in, 4-bit value and valid out) SHALL implement REQ-019.

Verification
REQ-030 Scan of digits 0..7 showing 1,2,3,4,5,6,7,8, dwell 8 cycles each, COM_ACTIVE_LOW=1 -> one frame_done; digit_o=32'h87654321; digit_vld=8'hFF.
REQ-031 Digit 3 segOut=7'b1111111 ("8") then 7'b0000001 ("-") -> nibble 3 = 0x0 and digit_vld[3]=0 in the next frame.
REQ-032 Dwell of SETTLE_CYC-1 cycles per digit -> no capture and no frame_done; with SEG_SCAN_TIMEOUT_EN defined, scan_lost=1 after 256 cycles.
REQ-033 Stable ComOut=8'b11110011 for 8 cycles -> exactly one err_com pulse and no write.
REQ-034 RST=0 after 5 digits are captured, then a full scan -> frame_done only after all 8 digits are recaptured; outputs read 0 during reset.
REQ-035 Scan halted for 300 cycles, then resumed -> scan_lost rises at cycle 256 and falls on the first valid capture.
